// File: rtl/execute_stage.sv
// RISC-V execute stage: ID/EX register, forwarding muxes, ALU, branch resolution
// and an optional iterative shift-add multiplier that stalls the stage while busy.
module execute_stage #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             JalrD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ResultSrcD,
    input  logic [3:0]       ALUControlD,
    input  logic [2:0]       BranchTypeD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] PCD,
    input  logic [WIDTH-1:0] ImmExtD,
    input  logic [WIDTH-1:0] PCPlus4D,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             FlushE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] ResultW,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             PCSrcE,
    output logic             BusyE,
    output logic [1:0]       ResultSrcE,
    output logic [WIDTH-1:0] ALUResultE,
    output logic [WIDTH-1:0] WriteDataE,
    output logic [WIDTH-1:0] PCTargetE,
    output logic [WIDTH-1:0] PCPlus4E,
    output logic [4:0]       RdE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic logic [WIDTH-1:0] alu_op(input logic [3:0]       ctrl,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] mul_res);
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (ctrl)
            4'b0000: alu_op = a + b;
            4'b0001: alu_op = a - b;
            4'b0010: alu_op = a & b;
            4'b0011: alu_op = a | b;
            4'b0100: alu_op = a ^ b;
            4'b0101: alu_op = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            4'b0110: alu_op = (a < b) ? WIDTH'(1) : '0;
            4'b0111: alu_op = a << sh;
            4'b1000: alu_op = a >> sh;
            4'b1001: alu_op = $unsigned($signed(a) >>> sh);
            4'b1010: alu_op = b;
            4'b1011: alu_op = (MUL_EN != 0) ? mul_res : a + b;
            default: alu_op = '0;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0]       bt,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        case (bt)
            3'b000:  br_taken = (a == b);
            3'b001:  br_taken = (a != b);
            3'b100:  br_taken = ($signed(a) < $signed(b));
            3'b101:  br_taken = ($signed(a) >= $signed(b));
            3'b110:  br_taken = (a < b);
            3'b111:  br_taken = (a >= b);
            default: br_taken = 1'b0;
        endcase
    endfunction

    // ---- stage p0: ID/EX register ----
    logic             reg_write_p0, mem_write_p0, jump_p0, branch_p0, jalr_p0, alu_src_p0;
    logic [1:0]       result_src_p0;
    logic [3:0]       alu_ctrl_p0;
    logic [2:0]       branch_type_p0;
    logic [WIDTH-1:0] rd1_p0, rd2_p0, pc_p0, imm_p0, pc_plus4_p0;
    logic [4:0]       rs1_p0, rs2_p0, rd_p0;

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            reg_write_p0   <= 1'b0;
            mem_write_p0   <= 1'b0;
            jump_p0        <= 1'b0;
            branch_p0      <= 1'b0;
            jalr_p0        <= 1'b0;
            alu_src_p0     <= 1'b0;
            result_src_p0  <= '0;
            alu_ctrl_p0    <= '0;
            branch_type_p0 <= '0;
            rd1_p0         <= '0;
            rd2_p0         <= '0;
            pc_p0          <= '0;
            imm_p0         <= '0;
            pc_plus4_p0    <= '0;
            rs1_p0         <= '0;
            rs2_p0         <= '0;
            rd_p0          <= '0;
        end else if (!BusyE) begin
            reg_write_p0   <= RegWriteD;
            mem_write_p0   <= MemWriteD;
            jump_p0        <= JumpD;
            branch_p0      <= BranchD;
            jalr_p0        <= JalrD;
            alu_src_p0     <= ALUSrcD;
            result_src_p0  <= ResultSrcD;
            alu_ctrl_p0    <= ALUControlD;
            branch_type_p0 <= BranchTypeD;
            rd1_p0         <= RD1D;
            rd2_p0         <= RD2D;
            pc_p0          <= PCD;
            imm_p0         <= ImmExtD;
            pc_plus4_p0    <= PCPlus4D;
            rs1_p0         <= Rs1D;
            rs2_p0         <= Rs2D;
            rd_p0          <= RdD;
        end
    end

    // ---- stage p0 combinational: forwarding, ALU, branch ----
    logic [WIDTH-1:0] src_a, fwd_b, src_b;

    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = rd1_p0;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = rd2_p0;
        endcase
        src_b = alu_src_p0 ? imm_p0 : fwd_b;
    end

    // Multiplier: operands are captured on the entry cycle, then one multiplier
    // bit is retired per cycle; the last bit is folded in combinationally.
    logic             mul_active;
    logic [CNT_W-1:0] mul_cnt;
    logic [WIDTH-1:0] mul_a, mul_b, mul_acc, mul_res;
    logic             mul_valid;

    assign mul_valid = (MUL_EN != 0) && (alu_ctrl_p0 == 4'b1011);
    assign mul_res   = mul_acc + (mul_b[0] ? mul_a : '0);
    assign BusyE     = mul_valid && !(mul_active && mul_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            mul_active <= 1'b0;
            mul_cnt    <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_acc    <= '0;
        end else if (mul_valid && !mul_active) begin
            mul_active <= 1'b1;
            mul_cnt    <= CNT_W'(WIDTH);
            mul_a      <= src_a;
            mul_b      <= src_b;
            mul_acc    <= '0;
        end else if (mul_active) begin
            if (mul_cnt == CNT_W'(1)) begin
                mul_active <= 1'b0;
                mul_cnt    <= '0;
            end else begin
                mul_acc <= mul_res;
                mul_a   <= mul_a << 1;
                mul_b   <= mul_b >> 1;
                mul_cnt <= mul_cnt - CNT_W'(1);
            end
        end
    end

    assign ALUResultE = alu_op(alu_ctrl_p0, src_a, src_b, mul_res);
    assign WriteDataE = fwd_b;
    assign PCTargetE  = jalr_p0 ? ((src_a + imm_p0) & {{(WIDTH-1){1'b1}}, 1'b0})
                                : (pc_p0 + imm_p0);
    assign RegWriteE  = reg_write_p0 & ~BusyE;
    assign MemWriteE  = mem_write_p0 & ~BusyE;
    assign PCSrcE     = (jump_p0 | (branch_p0 & br_taken(branch_type_p0, src_a, fwd_b))) & ~BusyE;
    assign ResultSrcE = result_src_p0;
    assign PCPlus4E   = pc_plus4_p0;
    assign RdE        = rd_p0;
    assign Rs1E       = rs1_p0;
    assign Rs2E       = rs2_p0;

endmodule
